// File: rtl/conf_int_mul_seq_responder_if.sv
// ----------------------------------------------------------------------------
// conf_int_mul_seq_responder_if
// Operand/result bundle between a multiplier vector source/sink and the
// sequential multiplier responder.
//   Operand channel : in_valid, in_ready, a, b, apx_lsb
//   Result channel  : out_valid, out_ready, d
//   Status          : busy
// Modports:
//   master : the driving side (vector source and result sink)
//   slave  : the multiplier itself
// ----------------------------------------------------------------------------
interface conf_int_mul_seq_responder_if #(
  parameter int DATA_PATH_BITWIDTH = 32,
  parameter int APX_W              = 5
);
  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_PATH_BITWIDTH-1:0] a;
  logic [DATA_PATH_BITWIDTH-1:0] b;
  logic [APX_W-1:0]              apx_lsb;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_PATH_BITWIDTH-1:0] d;
  logic                          busy;

  modport master (
    output in_valid, a, b, apx_lsb, out_ready,
    input  in_ready, out_valid, d, busy
  );

  modport slave (
    input  in_valid, a, b, apx_lsb, out_ready,
    output in_ready, out_valid, d, busy
  );
endinterface

// File: rtl/conf_int_mul_seq_responder.sv
// ----------------------------------------------------------------------------
// conf_int_mul_seq_responder
// Sequential radix-2 shift-add signed multiplier with configurable accuracy.
// One operand pair is accepted at a time. The product is returned on a second
// valid/ready handshake after a fixed OP_BITWIDTH+1 cycle computation.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of conf_int_mul_seq_responder_if
//           in_valid/in_ready/a/b/apx_lsb : operand pair and approximation
//           out_valid/out_ready/d         : signed product (low bits)
//           busy                          : high while computing or holding
// ----------------------------------------------------------------------------
module conf_int_mul_seq_responder #(
  parameter int OP_BITWIDTH        = 28,
  parameter int DATA_PATH_BITWIDTH = 32,
  parameter int APX_W              = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  conf_int_mul_seq_responder_if.slave   bus
);

  // Magnitudes carry one extra bit so |-2^(OP_BITWIDTH-1)| is representable.
  localparam int MAG_W = OP_BITWIDTH + 1;
  // Wide enough for the largest magnitude product: never overflows.
  localparam int ACC_W = 2 * OP_BITWIDTH + 2;
  localparam int CNT_W = $clog2(OP_BITWIDTH + 1);
  localparam int RES_W = ACC_W + DATA_PATH_BITWIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_BITWIDTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t                        state_q, state_d;
  logic [MAG_W-1:0]              a_mag_q, b_mag_q;
  logic                          sign_q;
  logic [ACC_W-1:0]              acc_q;
  logic [CNT_W-1:0]              cnt_q;
  logic [DATA_PATH_BITWIDTH-1:0] d_q;

  // --------------------------------------------------------------------------
  // Operand conditioning at accept: sign-extend from the top significant bit,
  // take magnitudes, then clear the requested number of magnitude LSBs.
  // --------------------------------------------------------------------------
  logic [MAG_W-1:0] a_ext, b_ext;
  logic [MAG_W-1:0] a_abs, b_abs;
  logic [MAG_W-1:0] mag_mask;
  logic             apx_kill;

  assign a_ext    = {bus.a[OP_BITWIDTH-1], bus.a[OP_BITWIDTH-1:0]};
  assign b_ext    = {bus.b[OP_BITWIDTH-1], bus.b[OP_BITWIDTH-1:0]};
  assign a_abs    = a_ext[MAG_W-1] ? -a_ext : a_ext;
  assign b_abs    = b_ext[MAG_W-1] ? -b_ext : b_ext;
  // Any shift at or beyond the operand width wipes the whole magnitude,
  // including the extra bit used only by the most negative value.
  assign apx_kill = int'(bus.apx_lsb) >= OP_BITWIDTH;
  assign mag_mask = apx_kill ? '0 : ({MAG_W{1'b1}} << bus.apx_lsb);

  // Operand bits above the significant width are intentionally ignored.
  generate
    if (OP_BITWIDTH < DATA_PATH_BITWIDTH) begin : g_unused_hi
      logic unused_hi_bits;
      assign unused_hi_bits = ^{bus.a[DATA_PATH_BITWIDTH-1:OP_BITWIDTH],
                                bus.b[DATA_PATH_BITWIDTH-1:OP_BITWIDTH]};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // One shift-add step and the signed, truncated result of the final step.
  // --------------------------------------------------------------------------
  logic [ACC_W-1:0]              addend;
  logic [ACC_W-1:0]              acc_step;
  logic [RES_W-1:0]              res_wide;
  logic [RES_W-1:0]              res_signed;
  logic [DATA_PATH_BITWIDTH-1:0] d_next;

  assign addend     = b_mag_q[cnt_q] ? (ACC_W'(a_mag_q) << cnt_q) : '0;
  assign acc_step   = acc_q + addend;
  // Widen before negating so the truncated result is correctly sign-extended
  // even when the data path is wider than the accumulator.
  assign res_wide   = RES_W'(acc_step);
  assign res_signed = sign_q ? -res_wide : res_wide;
  assign d_next     = res_signed[DATA_PATH_BITWIDTH-1:0];

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaulting state_d first keeps every path assigned, so no latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.in_valid)         state_d = BUSY;
      BUSY: if (cnt_q == CNT_LAST)    state_d = DONE;
      DONE: if (bus.out_ready)        state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.d         = d_q;

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_mag_q <= '0;
      b_mag_q <= '0;
      sign_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      d_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_mag_q <= a_abs & mag_mask;
            b_mag_q <= b_abs & mag_mask;
            sign_q  <= a_ext[MAG_W-1] ^ b_ext[MAG_W-1];
            acc_q   <= '0;
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) d_q <= d_next;
        end
        default: ;  // DONE: everything held until the result is taken
      endcase
    end
  end

endmodule

// File: tb/tb_conf_int_mul_seq_responder.sv
// ----------------------------------------------------------------------------
// tb_conf_int_mul_seq_responder
// Directed table of operand pairs with hand-computed products, hand-written
// backpressure and mid-operation reset sequences, and a randomized run
// compared against an integer reference model.
// ----------------------------------------------------------------------------
module tb_conf_int_mul_seq_responder;

  localparam int OP = 28;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int LAT = OP + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  conf_int_mul_seq_responder_if #(.DATA_PATH_BITWIDTH(DW), .APX_W(AW)) bus ();

  conf_int_mul_seq_responder #(
    .OP_BITWIDTH(OP),
    .DATA_PATH_BITWIDTH(DW),
    .APX_W(AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string         name;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [AW-1:0] apx;
    logic [DW-1:0] exp_d;
  } vec_t;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Independent reference: plain integer arithmetic on sign-extended values.
  function automatic logic [DW-1:0] model(input logic [DW-1:0] a,
                                          input logic [DW-1:0] b,
                                          input logic [AW-1:0] apx);
    logic signed [OP-1:0] ta, tb;
    longint sa, sb, ma, mb, p;
    ta = a[OP-1:0];
    tb = b[OP-1:0];
    sa = longint'(ta);
    sb = longint'(tb);
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    if (int'(apx) >= OP) begin
      ma = 0;
      mb = 0;
    end else begin
      ma = (ma >> apx) << apx;
      mb = (mb >> apx) << apx;
    end
    p = ma * mb;
    if ((sa < 0) != (sb < 0)) p = -p;
    return p[DW-1:0];
  endfunction

  // Present a pair at a negedge and return on the negedge after acceptance.
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [AW-1:0] apx);
    int guard;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.apx_lsb  = apx;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("accept_timeout", DW'(bus.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Count negedges (one per posedge) until out_valid shows up.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) check("result_timeout", DW'(bus.out_valid), 1);
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    int lat;
    logic [DW-1:0] held_d;
    int seen;

    vecs.push_back('{"exact_3x-5",      32'h0000_0003, 32'hFFFF_FFFB, 5'd0,  32'hFFFF_FFF1});
    vecs.push_back('{"max_pos_x2",      32'h07FF_FFFF, 32'h0000_0002, 5'd0,  32'h0FFF_FFFE});
    vecs.push_back('{"min_neg_sq",      32'h0800_0000, 32'h0800_0000, 5'd0,  32'h0000_0000});
    vecs.push_back('{"min_neg_x-1",     32'h0800_0000, 32'hFFFF_FFFF, 5'd0,  32'h0800_0000});
    vecs.push_back('{"upper_mask",      32'hF000_0003, 32'h0000_0004, 5'd0,  32'h0000_000C});
    vecs.push_back('{"apx2_19x11",      32'h0000_0013, 32'h0000_000B, 5'd2,  32'h0000_0080});
    vecs.push_back('{"apx2_-19x11",     32'hFFFF_FFED, 32'h0000_000B, 5'd2,  32'hFFFF_FF80});
    vecs.push_back('{"apx28_zero",      32'h0000_0013, 32'h0000_000B, 5'd28, 32'h0000_0000});
    vecs.push_back('{"apx31_zero",      32'h07FF_FFFF, 32'h0800_0000, 5'd31, 32'h0000_0000});
    vecs.push_back('{"zero_operand",    32'h0000_0000, 32'h0000_1234, 5'd0,  32'h0000_0000});

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.apx_lsb   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready",  DW'(bus.in_ready),  1);
    check("rst_out_valid", DW'(bus.out_valid), 0);
    check("rst_busy",      DW'(bus.busy),      0);
    check("rst_d",         bus.d,              0);
    rst_n = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].apx);
      wait_result(lat);
      check({vecs[i].name, "_d"}, bus.d, vecs[i].exp_d);
      check({vecs[i].name, "_latency"}, DW'(lat), DW'(LAT));
      take_result();
    end

    // Backpressure: result held, second pair waits until after the handshake
    send(32'd100, 32'hFFFF_FFFD, 5'd0);
    wait_result(lat);
    check("bp_d", bus.d, 32'hFFFF_FED4);
    held_d = bus.d;
    bus.in_valid = 1'b1;
    bus.a        = 32'd6;
    bus.b        = 32'd7;
    bus.apx_lsb  = 5'd0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_d_stable",   bus.d,              held_d);
      check("bp_in_ready",   DW'(bus.in_ready),  0);
      check("bp_out_valid",  DW'(bus.out_valid), 1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("hs_no_accept_busy", DW'(bus.busy),      0);
    check("hs_in_ready",       DW'(bus.in_ready),  1);
    check("hs_out_valid",      DW'(bus.out_valid), 0);
    check("hs_d_held",         bus.d,              held_d);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("second_accept_busy", DW'(bus.busy), 1);
    wait_result(lat);
    check("second_d",       bus.d,    32'h0000_002A);
    check("second_latency", DW'(lat), DW'(LAT));
    take_result();

    // Randomized pairs with random sink backpressure
    for (int n = 0; n < 500; n++) begin
      logic [DW-1:0] ra, rb, exp_d;
      logic [AW-1:0] rapx;
      logic          hs;
      ra   = $urandom;
      rb   = $urandom;
      rapx = ($urandom_range(3) == 0) ? AW'($urandom_range(31)) : '0;
      if (n % 50 == 0) ra = 32'h0800_0000;
      exp_d = model(ra, rb, rapx);
      send(ra, rb, rapx);
      wait_result(lat);
      hs = 1'b0;
      for (int k = 0; k < 40 && !hs; k++) begin
        check("rand_d", bus.d, exp_d);
        bus.out_ready = (k == 39) ? 1'b1 : 1'($urandom_range(1));
        hs = bus.out_ready;
        @(posedge clk);
        @(negedge clk);
      end
      bus.out_ready = 1'b0;
    end

    // Asynchronous reset in the middle of an operation
    send(32'd7, 32'd9, 5'd0);
    repeat (5) @(negedge clk);
    check("pre_rst_busy", DW'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy",      DW'(bus.busy),      0);
    check("async_rst_out_valid", DW'(bus.out_valid), 0);
    check("async_rst_in_ready",  DW'(bus.in_ready),  1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", DW'(bus.in_ready), 1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("no_result_after_rst", DW'(seen), 0);
    check("post_rst_d",          bus.d,     0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conf_int_mul_seq_responder.md
Name: conf_int_mul_seq_responder

Overview:
- Operand-consuming end of the operand/result interface that our multiplier benches drive.
- Accepts one signed operand pair at a time over a valid/ready handshake.
- Computes a configurable-accuracy product with an iterative radix-2 shift-add datapath.
- Returns the result over a second valid/ready handshake; sits between a vector source and a result sink in the functional regression flow.

Parameters:
- OP_BITWIDTH, 28: significant operand width; operand bits at and above this position are ignored; legal range 2 to DATA_PATH_BITWIDTH.
- DATA_PATH_BITWIDTH, 32: width of the operand and result buses.
- APX_W, 5: width of the approximation-control input.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept a pair.
- a  in  DATA_PATH_BITWIDTH  operand A; bits [OP_BITWIDTH-1:0] are a two's-complement value.
- b  in  DATA_PATH_BITWIDTH  operand B; same format as a.
- apx_lsb  in  APX_W  number of operand-magnitude LSBs forced to zero; 0 gives an exact product.
- out_valid  out  1  result present.
- out_ready  in  1  sink accepts the result.
- d  out  DATA_PATH_BITWIDTH  low DATA_PATH_BITWIDTH bits of the signed product.
- busy  out  1  high in BUSY and DONE.

Behaviour:
- Reset (asynchronous, active-low):
  - State IDLE, in_ready=1, out_valid=0, d=0, busy=0.
  - Internal accumulator, operand registers and counter cleared.
  - Reset mid-operation aborts the operation; no result is ever emitted for it.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid && in_ready: sign-extend a and b from bit OP_BITWIDTH-1.
  - Register the magnitudes |a|, |b| (OP_BITWIDTH+1 bits, so the most negative value is handled), sign = sign(a) XOR sign(b), and apx_lsb.
  - Clear the accumulator, set cnt=0, go to BUSY.
- Approximation:
  - At accept, the low apx_lsb bits of both magnitudes are zeroed.
  - apx_lsb >= OP_BITWIDTH zeroes both magnitudes, so the product is 0.
  - apx_lsb is sampled only at accept; later changes have no effect on the operation in flight.
- BUSY:
  - in_ready=0.
  - Each cycle: if bit cnt of |b| is 1, accumulator += |a| << cnt; then cnt++.
  - The accumulator is 2*OP_BITWIDTH+2 bits wide, so it never overflows.
  - On the edge that processes cnt = OP_BITWIDTH (OP_BITWIDTH+1 iterations, covering the magnitude MSB), go to DONE.
  - On that same edge, d = (sign ? -acc : acc) truncated to DATA_PATH_BITWIDTH, and out_valid=1.
- DONE:
  - out_valid=1; d is held stable.
  - On the edge where out_valid && out_ready: out_valid=0, go to IDLE.
  - No new pair is accepted on that same edge.
- Latency: accept at edge k gives out_valid=1 after edge k+OP_BITWIDTH+1.
- Throughput with out_ready held high: one pair per OP_BITWIDTH+3 cycles.
- d holds its last value after a handshake until the next result is produced.
- Values of a, b and in_valid are ignored outside IDLE.
- Zero operands take no shortcut; latency is constant.

Test Plan:
- Reset: rst_n=0 asserted asynchronously in the middle of BUSY (a=7, b=9) → out_valid drops to 0 immediately and no result appears after release; in_ready=1 the cycle after release.
- Exact: a=3, b=0xFFFFFFFB (-5), apx_lsb=0 → d=0xFFFFFFF1 (-15), out_valid exactly OP_BITWIDTH+1 edges after accept.
- Boundary: a=0x07FFFFFF, b=2, apx_lsb=0 → d=0x0FFFFFFE. Then a=0x08000000 (-2^27), b=0x08000000 → d=0x00000000 (low 32 bits of 2^54).
- Upper-bit masking: a=0xF0000003, b=0x00000004, apx_lsb=0 → d=0x0000000C.
- Approximate: a=19, b=11, apx_lsb=2 → d=0x80 (16*8). a=-19, b=11, apx_lsb=2 → d=0xFFFFFF80. apx_lsb=28 → d=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → d stable, in_ready=0; a second pair on in_valid is not accepted until the cycle after the out handshake; 500 random pairs with random out_ready all match the reference model.
